// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Iterative RV32M multiply/divide sequencer. It accepts one
//             M-extension op, runs 32 iterations on a single shared 33-bit
//             add/sub datapath, applies a sign fixup and returns a
//             registered result with a one-cycle done pulse.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous active-high reset
//             start  - op request, taken only while ready
//             flush  - kills the in-flight op (no done pulse)
//             inst   - instruction word, funct3 = inst[14:12]
//             in_a   - rs1 value, sampled on accept
//             in_b   - rs2 value, sampled on accept
//             ready  - high in IDLE only
//             busy   - high from the cycle after accept through done
//             done   - one-cycle completion pulse
//             result - registered result, held until the next done
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] c_s_idle    = 3'd0;
    localparam logic [2:0] c_s_mul_it  = 3'd1;
    localparam logic [2:0] c_s_div_it  = 3'd2;
    localparam logic [2:0] c_s_fix     = 3'd3;
    localparam logic [2:0] c_s_special = 3'd4;
    localparam logic [2:0] c_s_done    = 3'd5;

    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_rem    = 3'b110;

    logic [2:0]      r_state;
    logic [4:0]      r_count;
    logic [2:0]      r_funct3;
    logic            r_neg;
    logic [XLEN:0]   r_hi;      // product high word (with carry) / remainder
    logic [XLEN-1:0] r_lo;      // multiplier->product low / dividend->quotient
    logic [XLEN-1:0] r_op;      // multiplicand / divisor
    logic [XLEN-1:0] r_result;
    logic            r_done;
    logic            r_busy;

    // ------------------------------------------------------------------
    // Accept-time decode and sign preparation
    // ------------------------------------------------------------------
    logic [2:0]      w_f3;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_neg;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic [XLEN-1:0] w_special_val;
    logic            w_unused_inst;

    assign w_f3          = inst[14:12];
    assign w_is_div      = w_f3[2];
    assign w_unused_inst = ^{inst[31:15], inst[11:0]};

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (w_f3)
            c_f3_mulh:   begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            c_f3_mulhsu: begin w_a_signed = 1'b1; end
            c_f3_div:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            c_f3_rem:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default:     begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
    end

    assign w_sa    = in_a[XLEN-1] & w_a_signed;
    assign w_sb    = in_b[XLEN-1] & w_b_signed;
    assign w_mag_a = w_sa ? ({XLEN{1'b0}} - in_a) : in_a;
    assign w_mag_b = w_sb ? ({XLEN{1'b0}} - in_b) : in_b;

    // Result sign: REM follows the dividend, everything else XORs the
    // operand signs (unsigned operands contribute a zero sign).
    always_comb begin
        w_neg = 1'b0;
        if (w_f3 == c_f3_rem) begin
            w_neg = w_sa;
        end else begin
            w_neg = w_sa ^ w_sb;
        end
    end

    assign w_div_zero = w_is_div && (in_b == {XLEN{1'b0}});
    assign w_div_ovf  = ((w_f3 == c_f3_div) || (w_f3 == c_f3_rem)) &&
                        (in_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (in_b == {XLEN{1'b1}});

    // w_f3[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        w_special_val = {XLEN{1'b0}};
        if (w_div_zero) begin
            w_special_val = w_f3[1] ? in_a : {XLEN{1'b1}};
        end else if (w_div_ovf) begin
            w_special_val = w_f3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Shared 33-bit add/sub: add for multiply, subtract for divide
    // ------------------------------------------------------------------
    logic            w_sub;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_add_a;
    logic [XLEN:0]   w_add_b;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_mul_acc;
    logic            w_trial_ok;

    assign w_sub       = (r_state == c_s_div_it);
    assign w_div_shift = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
    assign w_add_a     = w_sub ? w_div_shift : r_hi;
    assign w_add_b     = {1'b0, r_op};
    assign w_sum       = w_add_a + (w_sub ? ~w_add_b : w_add_b) + {{XLEN{1'b0}}, w_sub};

    assign w_mul_acc   = r_lo[0] ? w_sum : r_hi;
    // A non-negative trial (bit 32 clear) means the divisor fits
    assign w_trial_ok  = ~w_sum[XLEN];

    // ------------------------------------------------------------------
    // Sign fixup and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;

    assign w_prod     = {r_hi[XLEN-1:0], r_lo};
    assign w_prod_fix = r_neg ? ({(2*XLEN){1'b0}} - w_prod) : w_prod;
    assign w_quo_fix  = r_neg ? ({XLEN{1'b0}} - r_lo) : r_lo;
    assign w_rem_fix  = r_neg ? ({XLEN{1'b0}} - r_hi[XLEN-1:0]) : r_hi[XLEN-1:0];

    always_comb begin
        w_fix_result = {XLEN{1'b0}};
        if (r_funct3 == c_f3_mul) begin
            w_fix_result = w_prod_fix[XLEN-1:0];
        end else if (!r_funct3[2]) begin
            w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
        end else if (!r_funct3[1]) begin
            w_fix_result = w_quo_fix;
        end else begin
            w_fix_result = w_rem_fix;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_s_idle;
            r_count  <= 5'd0;
            r_funct3 <= 3'd0;
            r_neg    <= 1'b0;
            r_hi     <= {(XLEN+1){1'b0}};
            r_lo     <= {XLEN{1'b0}};
            r_op     <= {XLEN{1'b0}};
            r_result <= {XLEN{1'b0}};
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else if (flush && (r_state != c_s_idle)) begin
            r_state <= c_s_idle;
            r_count <= 5'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    r_done <= 1'b0;
                    if (start && !flush) begin
                        r_funct3 <= w_f3;
                        r_neg    <= w_neg;
                        r_count  <= 5'd0;
                        r_busy   <= 1'b1;
                        r_hi     <= {(XLEN+1){1'b0}};
                        if (w_div_zero || w_div_ovf) begin
                            // Special value parked in r_lo until SPECIAL
                            r_lo    <= w_special_val;
                            r_op    <= {XLEN{1'b0}};
                            r_state <= c_s_special;
                        end else if (w_is_div) begin
                            r_lo    <= w_mag_a;
                            r_op    <= w_mag_b;
                            r_state <= c_s_div_it;
                        end else begin
                            r_lo    <= w_mag_b;
                            r_op    <= w_mag_a;
                            r_state <= c_s_mul_it;
                        end
                    end
                end
                c_s_mul_it: begin
                    r_hi    <= {1'b0, w_mul_acc[XLEN:1]};
                    r_lo    <= {w_mul_acc[0], r_lo[XLEN-1:1]};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= c_s_fix;
                    end
                end
                c_s_div_it: begin
                    r_hi    <= w_trial_ok ? w_sum : w_div_shift;
                    r_lo    <= {r_lo[XLEN-2:0], w_trial_ok};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= c_s_fix;
                    end
                end
                c_s_fix: begin
                    r_result <= w_fix_result;
                    r_done   <= 1'b1;
                    r_state  <= c_s_done;
                end
                c_s_special: begin
                    r_result <= r_lo;
                    r_done   <= 1'b1;
                    r_state  <= c_s_done;
                end
                c_s_done: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_s_idle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_count <= 5'd0;
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

    assign ready  = (r_state == c_s_idle);
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire
